mem_arbiter: RTL

//  Shares the single 128-bit main-memory port between cache_I (read-only refills) and cache_D
//  (refills and write-backs). Sits between the two caches and the memory model.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side request/response signals and the shared main-memory port.
// The arbiter takes the slave view; caches plus the memory model take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;

    modport slave (
        input  i_read, i_addr,
        input  d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output i_read, i_addr,
        output d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one 128-bit memory port between I-cache refills and D-cache refills/write-backs.
// One grant at a time, held until mem_ready; round-robin or D-first on simultaneous requests.
module mem_arbiter #(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int PRIO_MODE = 0
) (
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_gnt;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_i_ready;
    logic              w_d_ready;
    logic              w_busy;

    assign w_i_req = bus.i_read;
    assign w_d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == GNT_I && bus.mem_ready) begin
                r_last_gnt <= 1'b0;
            end else if (r_state == GNT_D && bus.mem_ready) begin
                r_last_gnt <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_i_ready   = 1'b0;
        w_d_ready   = 1'b0;
        w_busy      = 1'b0;

        case (r_state)
            IDLE: begin
                // On a tie, last_gnt points at whoever was served most recently.
                if (w_i_req && w_d_req) begin
                    if (PRIO_MODE != 0) begin
                        w_next = GNT_D;
                    end else begin
                        w_next = r_last_gnt ? GNT_I : GNT_D;
                    end
                end else if (w_i_req) begin
                    w_next = GNT_I;
                end else if (w_d_req) begin
                    w_next = GNT_D;
                end
            end

            GNT_I: begin
                w_busy     = 1'b1;
                w_mem_read = 1'b1;
                w_mem_addr = bus.i_addr;
                if (bus.mem_ready) begin
                    w_i_ready = 1'b1;
                    w_next    = IDLE;
                end
            end

            GNT_D: begin
                w_busy      = 1'b1;
                w_mem_write = bus.d_write;
                w_mem_read  = bus.d_read & ~bus.d_write;
                w_mem_addr  = bus.d_addr;
                w_mem_wdata = bus.d_wdata;
                if (bus.mem_ready) begin
                    w_d_ready = 1'b1;
                    w_next    = IDLE;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Strobes are forced low while reset is held so nothing leaks during the reset cycle.
    assign bus.mem_read  = w_mem_read  & ~proc_reset;
    assign bus.mem_write = w_mem_write & ~proc_reset;
    assign bus.mem_addr  = proc_reset ? '0 : w_mem_addr;
    assign bus.mem_wdata = proc_reset ? '0 : w_mem_wdata;
    assign bus.i_ready   = w_i_ready & ~proc_reset;
    assign bus.d_ready   = w_d_ready & ~proc_reset;
    assign bus.busy      = w_busy    & ~proc_reset;

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule
